// File: rtl/lc3_mmio.sv
// lc3_mmio: LC-3 memory-mapped I/O block (keyboard, display, machine control) in front of RAM.
// Optional macro LC3_MMIO_KBD_FIFO_EN selects a 4-entry keyboard FIFO instead of a single register.
`default_nettype none

module lc3_mmio (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] MAROut,
    input  logic [15:0] MDROut,
    input  logic        memWE,
    input  logic        ldMDR,
    input  logic [15:0] memIn,
    output logic [15:0] MDRIn,
    output logic        ramWE,
    input  logic [7:0]  kbdData,
    input  logic        kbdValid,
    output logic        kbdReady,
    output logic [7:0]  dispData,
    output logic        dispValid,
    input  logic        dispReady,
    output logic        mcrRun,
    output logic        intReq
);

    localparam logic [15:0] ADDR_KBSR = 16'hFE00;
    localparam logic [15:0] ADDR_KBDR = 16'hFE02;
    localparam logic [15:0] ADDR_DSR  = 16'hFE04;
    localparam logic [15:0] ADDR_DDR  = 16'hFE06;
    localparam logic [15:0] ADDR_MCR  = 16'hFFFE;

    logic is_kbsr, is_kbdr, is_dsr, is_ddr, is_mcr, is_device;
    logic kbd_avail, kbd_full, kbd_push, kbd_pop;
    logic [7:0] kbd_head, kbd_last;
    logic kbd_ie, dsp_ie, ovr, dsp_rdy;
    logic unused_mdr_bits;

    assign is_kbsr   = (MAROut == ADDR_KBSR);
    assign is_kbdr   = (MAROut == ADDR_KBDR);
    assign is_dsr    = (MAROut == ADDR_DSR);
    assign is_ddr    = (MAROut == ADDR_DDR);
    assign is_mcr    = (MAROut == ADDR_MCR);
    assign is_device = is_kbsr | is_kbdr | is_dsr | is_ddr | is_mcr;

    assign ramWE    = memWE & ~is_device;
    assign kbdReady = ~kbd_full;
    assign kbd_push = kbdValid & ~kbd_full;
    // A simultaneous store wins over the load, so a store to KBDR never pops.
    assign kbd_pop  = ldMDR & ~memWE & is_kbdr & kbd_avail;
    assign dsp_rdy  = ~dispValid;
    assign intReq   = (kbd_avail & kbd_ie) | (dsp_rdy & dsp_ie);
    assign unused_mdr_bits = ^MDROut[13:8];

`ifdef LC3_MMIO_KBD_FIFO_EN
    logic [7:0] fifo_mem [4];
    logic [1:0] rd_ptr, wr_ptr;
    logic [2:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (kbd_push) wr_ptr <= wr_ptr + 2'd1;
            if (kbd_pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({kbd_push, kbd_pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (kbd_push) fifo_mem[wr_ptr] <= kbdData;
    end

    assign kbd_avail = (count != 3'd0);
    assign kbd_full  = count[2];
    assign kbd_head  = fifo_mem[rd_ptr];
`else
    logic [7:0] kbd_reg;
    logic       kbd_valid;

    // Push needs an empty register and pop needs a full one, so they never coincide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kbd_reg   <= 8'h00;
            kbd_valid <= 1'b0;
        end else if (kbd_push) begin
            kbd_reg   <= kbdData;
            kbd_valid <= 1'b1;
        end else if (kbd_pop) begin
            kbd_valid <= 1'b0;
        end
    end

    assign kbd_avail = kbd_valid;
    assign kbd_full  = kbd_valid;
    assign kbd_head  = kbd_reg;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kbd_last <= 8'h00;
            kbd_ie   <= 1'b0;
        end else begin
            if (kbd_pop) kbd_last <= kbd_head;
            if (memWE && is_kbsr) kbd_ie <= MDROut[14];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dispValid <= 1'b0;
            dispData  <= 8'h00;
            dsp_ie    <= 1'b0;
            ovr       <= 1'b0;
            mcrRun    <= 1'b1;
        end else begin
            if (dispValid && dispReady) dispValid <= 1'b0;
            if (memWE && is_ddr) begin
                if (!dispValid) begin
                    dispValid <= 1'b1;
                    dispData  <= MDROut[7:0];
                end else begin
                    ovr <= 1'b1;
                end
            end
            if (memWE && is_dsr) begin
                dsp_ie <= MDROut[14];
                ovr    <= 1'b0;
            end
            if (memWE && is_mcr) mcrRun <= MDROut[15];
        end
    end

    always_comb begin
        MDRIn = memIn;
        if (is_kbsr)      MDRIn = {kbd_avail, kbd_ie, 14'b0};
        else if (is_kbdr) MDRIn = {8'h00, (kbd_avail ? kbd_head : kbd_last)};
        else if (is_dsr)  MDRIn = {dsp_rdy, dsp_ie, 12'b0, ovr, 1'b0};
        else if (is_ddr)  MDRIn = {8'h00, dispData};
        else if (is_mcr)  MDRIn = {mcrRun, 15'b0};
    end

endmodule

`default_nettype wire

// File: tb/tb_lc3_mmio.sv
// tb_lc3_mmio: directed table, corner sequences and random traffic against a queue-based model.
`default_nettype none

module tb_lc3_mmio;

`ifdef LC3_MMIO_KBD_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] MAROut = 16'h0, MDROut = 16'h0, memIn = 16'h0;
    logic        memWE = 1'b0, ldMDR = 1'b0, kbdValid = 1'b0, dispReady = 1'b0;
    logic [7:0]  kbdData = 8'h0;
    logic [15:0] MDRIn;
    logic        ramWE, kbdReady, dispValid, mcrRun, intReq;
    logic [7:0]  dispData;

    lc3_mmio dut (
        .clk(clk), .reset(reset), .MAROut(MAROut), .MDROut(MDROut),
        .memWE(memWE), .ldMDR(ldMDR), .memIn(memIn), .MDRIn(MDRIn), .ramWE(ramWE),
        .kbdData(kbdData), .kbdValid(kbdValid), .kbdReady(kbdReady),
        .dispData(dispData), .dispValid(dispValid), .dispReady(dispReady),
        .mcrRun(mcrRun), .intReq(intReq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: device state kept as plain variables and a byte queue.
    logic [7:0] mq[$];
    logic [7:0] m_last, m_dd;
    logic       m_kie, m_dv, m_die, m_ovr, m_run;

    task automatic model_reset();
        mq.delete();
        m_last = 8'h00; m_dd = 8'h00;
        m_kie = 1'b0; m_dv = 1'b0; m_die = 1'b0; m_ovr = 1'b0; m_run = 1'b1;
    endtask

    function automatic logic is_dev(input logic [15:0] a);
        return (a == 16'hFE00) || (a == 16'hFE02) || (a == 16'hFE04) ||
               (a == 16'hFE06) || (a == 16'hFFFE);
    endfunction

    function automatic logic [15:0] m_mdr(input logic [15:0] a, input logic [15:0] mi);
        logic avail;
        avail = (mq.size() > 0);
        case (a)
            16'hFE00: return {avail, m_kie, 14'b0};
            16'hFE02: return {8'h00, (avail ? mq[0] : m_last)};
            16'hFE04: return {~m_dv, m_die, 12'b0, m_ovr, 1'b0};
            16'hFE06: return {8'h00, m_dd};
            16'hFFFE: return {m_run, 15'b0};
            default:  return mi;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [15:0] mar, input logic [15:0] mdr, input logic we,
                         input logic ld, input logic kv, input logic [7:0] kd,
                         input logic dr, input logic [15:0] mi);
        MAROut = mar; MDROut = mdr; memWE = we; ldMDR = ld;
        kbdValid = kv; kbdData = kd; dispReady = dr; memIn = mi;
    endtask

    task automatic check_model();
        logic avail;
        avail = (mq.size() > 0);
        chk("m_mdrin",    MDRIn,            m_mdr(MAROut, memIn));
        chk("m_ramwe",    {15'b0, ramWE},   {15'b0, memWE & ~is_dev(MAROut)});
        chk("m_kbdready", {15'b0, kbdReady}, {15'b0, (mq.size() < DEPTH)});
        chk("m_dispvalid",{15'b0, dispValid}, {15'b0, m_dv});
        chk("m_dispdata", {8'b0, dispData}, {8'b0, m_dd});
        chk("m_mcrrun",   {15'b0, mcrRun},  {15'b0, m_run});
        chk("m_intreq",   {15'b0, intReq},  {15'b0, (avail & m_kie) | (~m_dv & m_die)});
    endtask

    // Advance one clock and apply the architectural rules to the model.
    task automatic tick();
        logic pop, push, pre_dv;
        @(posedge clk);
        pop    = ldMDR && !memWE && (MAROut == 16'hFE02) && (mq.size() > 0);
        push   = kbdValid && (mq.size() < DEPTH);
        pre_dv = m_dv;
        if (pop) m_last = mq.pop_front();
        if (push) mq.push_back(kbdData);
        if (memWE) begin
            case (MAROut)
                16'hFE00: m_kie = MDROut[14];
                16'hFE04: begin m_die = MDROut[14]; m_ovr = 1'b0; end
                16'hFE06: if (!pre_dv) begin m_dv = 1'b1; m_dd = MDROut[7:0]; end
                          else m_ovr = 1'b1;
                16'hFFFE: m_run = MDROut[15];
                default: ;
            endcase
        end
        if (pre_dv && dispReady) m_dv = 1'b0;
        #1;
    endtask

    typedef struct {
        logic [15:0] mar, mdr;
        logic        we, ld, kv;
        logic [7:0]  kd;
        logic        dr, chk_mdr;
        logic [15:0] e_mdr;
        logic        e_ramwe, e_dv;
        logic [7:0]  e_dd;
        logic        e_int, e_run;
    } vec_t;

    vec_t tbl[30];

    function automatic vec_t mk(input logic [15:0] mar, input logic [15:0] mdr, input logic we,
                                input logic ld, input logic kv, input logic [7:0] kd,
                                input logic dr, input logic cm, input logic [15:0] em,
                                input logic ew, input logic edv, input logic [7:0] edd,
                                input logic ei, input logic er);
        vec_t v;
        v.mar = mar; v.mdr = mdr; v.we = we; v.ld = ld; v.kv = kv; v.kd = kd; v.dr = dr;
        v.chk_mdr = cm; v.e_mdr = em; v.e_ramwe = ew; v.e_dv = edv; v.e_dd = edd;
        v.e_int = ei; v.e_run = er;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //           mar       mdr       we ld kv kd     dr cm e_mdr     ew dv dd     int run
        tbl[0]  = mk(16'h3000, 16'h0000, 0, 1, 0, 8'h00, 0, 1, 16'hBEEF, 0, 0, 8'h00, 0, 1);
        tbl[1]  = mk(16'h3000, 16'h1234, 1, 0, 1, 8'h41, 0, 1, 16'hBEEF, 1, 0, 8'h00, 0, 1);
        tbl[2]  = mk(16'hFE00, 16'h0000, 0, 1, 0, 8'h00, 0, 1, 16'h8000, 0, 0, 8'h00, 0, 1);
        tbl[3]  = mk(16'hFE02, 16'h0000, 0, 1, 0, 8'h00, 0, 1, 16'h0041, 0, 0, 8'h00, 0, 1);
        tbl[4]  = mk(16'hFE00, 16'h0000, 0, 1, 0, 8'h00, 0, 1, 16'h0000, 0, 0, 8'h00, 0, 1);
        tbl[5]  = mk(16'hFE02, 16'h0000, 0, 1, 0, 8'h00, 0, 1, 16'h0041, 0, 0, 8'h00, 0, 1);
        tbl[6]  = mk(16'hFE06, 16'h0048, 1, 0, 0, 8'h00, 0, 0, 16'h0000, 0, 0, 8'h00, 0, 1);
        tbl[7]  = mk(16'hFE04, 16'h0000, 0, 1, 0, 8'h00, 0, 1, 16'h0000, 0, 1, 8'h48, 0, 1);
        tbl[8]  = mk(16'hFE04, 16'h0000, 0, 1, 0, 8'h00, 0, 1, 16'h0000, 0, 1, 8'h48, 0, 1);
        tbl[9]  = mk(16'hFE04, 16'h0000, 0, 1, 0, 8'h00, 0, 1, 16'h0000, 0, 1, 8'h48, 0, 1);
        tbl[10] = mk(16'hFE04, 16'h0000, 0, 1, 0, 8'h00, 1, 1, 16'h0000, 0, 1, 8'h48, 0, 1);
        tbl[11] = mk(16'hFE04, 16'h0000, 0, 1, 0, 8'h00, 0, 1, 16'h8000, 0, 0, 8'h48, 0, 1);
        tbl[12] = mk(16'hFE06, 16'h0055, 1, 0, 0, 8'h00, 0, 0, 16'h0000, 0, 0, 8'h48, 0, 1);
        tbl[13] = mk(16'hFE06, 16'h0066, 1, 0, 0, 8'h00, 0, 0, 16'h0000, 0, 1, 8'h55, 0, 1);
        tbl[14] = mk(16'hFE04, 16'h0000, 0, 1, 0, 8'h00, 0, 1, 16'h0002, 0, 1, 8'h55, 0, 1);
        tbl[15] = mk(16'hFE04, 16'h0000, 1, 0, 0, 8'h00, 0, 1, 16'h0002, 0, 1, 8'h55, 0, 1);
        tbl[16] = mk(16'hFE04, 16'h0000, 0, 1, 0, 8'h00, 0, 1, 16'h0000, 0, 1, 8'h55, 0, 1);
        tbl[17] = mk(16'hFE04, 16'h0000, 0, 1, 0, 8'h00, 1, 1, 16'h0000, 0, 1, 8'h55, 0, 1);
        tbl[18] = mk(16'hFE00, 16'h4000, 1, 0, 0, 8'h00, 0, 1, 16'h0000, 0, 0, 8'h55, 0, 1);
        tbl[19] = mk(16'hFE00, 16'h0000, 0, 1, 1, 8'h5A, 0, 1, 16'h4000, 0, 0, 8'h55, 0, 1);
        tbl[20] = mk(16'hFE00, 16'h0000, 0, 1, 0, 8'h00, 0, 1, 16'hC000, 0, 0, 8'h55, 1, 1);
        tbl[21] = mk(16'hFFFE, 16'h0000, 1, 0, 0, 8'h00, 0, 1, 16'h8000, 0, 0, 8'h55, 1, 1);
        tbl[22] = mk(16'hFFFE, 16'h0000, 0, 1, 0, 8'h00, 0, 1, 16'h0000, 0, 0, 8'h55, 1, 0);
        tbl[23] = mk(16'hFFFE, 16'h8000, 1, 0, 0, 8'h00, 0, 1, 16'h0000, 0, 0, 8'h55, 1, 0);
        tbl[24] = mk(16'hFFFE, 16'h0000, 0, 1, 0, 8'h00, 0, 1, 16'h8000, 0, 0, 8'h55, 1, 1);
        tbl[25] = mk(16'hFE02, 16'h0000, 1, 1, 0, 8'h00, 0, 1, 16'h005A, 0, 0, 8'h55, 1, 1);
        tbl[26] = mk(16'hFE00, 16'h0000, 0, 1, 0, 8'h00, 0, 1, 16'hC000, 0, 0, 8'h55, 1, 1);
        tbl[27] = mk(16'hFE02, 16'h0000, 0, 1, 0, 8'h00, 0, 1, 16'h005A, 0, 0, 8'h55, 1, 1);
        tbl[28] = mk(16'hFE00, 16'h0000, 0, 1, 0, 8'h00, 0, 1, 16'h4000, 0, 0, 8'h55, 0, 1);
        tbl[29] = mk(16'hFFFF, 16'h1111, 1, 0, 0, 8'h00, 0, 1, 16'hBEEF, 1, 0, 8'h55, 0, 1);

        model_reset();
        #12 reset = 1'b1;
        @(posedge clk); #1;

        // Directed table: constant expectations plus the model on every row.
        for (int i = 0; i < 30; i++) begin
            drive(tbl[i].mar, tbl[i].mdr, tbl[i].we, tbl[i].ld, tbl[i].kv, tbl[i].kd,
                  tbl[i].dr, 16'hBEEF);
            #2;
            if (tbl[i].chk_mdr) chk($sformatf("tbl%0d_mdrin", i), MDRIn, tbl[i].e_mdr);
            chk($sformatf("tbl%0d_ramwe", i), {15'b0, ramWE}, {15'b0, tbl[i].e_ramwe});
            chk($sformatf("tbl%0d_dv", i), {15'b0, dispValid}, {15'b0, tbl[i].e_dv});
            chk($sformatf("tbl%0d_dd", i), {8'b0, dispData}, {8'b0, tbl[i].e_dd});
            chk($sformatf("tbl%0d_int", i), {15'b0, intReq}, {15'b0, tbl[i].e_int});
            chk($sformatf("tbl%0d_run", i), {15'b0, mcrRun}, {15'b0, tbl[i].e_run});
            check_model();
            tick();
        end

        // Fill the keyboard buffer past capacity, then drain it in order.
        for (int i = 0; i < 5; i++) begin
            drive(16'h3000, 16'h0, 0, 0, 1, 8'h31 + 8'(i), 0, 16'hBEEF);
            #2;
            chk($sformatf("fill%0d_kbdready", i), {15'b0, kbdReady}, {15'b0, (i < DEPTH)});
            check_model();
            tick();
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(16'hFE02, 16'h0, 0, 1, 0, 8'h00, 0, 16'hBEEF);
            #2;
            chk($sformatf("drain%0d_kbdr", i), MDRIn, 16'h0031 + 16'(i));
            tick();
        end
        drive(16'hFE02, 16'h0, 0, 1, 0, 8'h00, 0, 16'hBEEF);
        #2;
        chk("drain_empty_kbdr", MDRIn, 16'h0030 + 16'(DEPTH));
        check_model();
        tick();

        // Reset in the middle of a display transfer with bytes buffered.
        drive(16'hFE06, 16'h0077, 1, 0, 1, 8'hA1, 0, 16'hBEEF); tick();
        drive(16'hFFFE, 16'h0000, 1, 0, 1, 8'hA2, 0, 16'hBEEF); tick();
        drive(16'hFE00, 16'h0000, 0, 0, 0, 8'h00, 0, 16'hBEEF);
        #1;
        chk("pre_rst_dv", {15'b0, dispValid}, 16'h0001);
        chk("pre_rst_kbsr", MDRIn, 16'hC000);
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_dv", {15'b0, dispValid}, 16'h0000);
        chk("rst_kbsr", MDRIn, 16'h0000);
        chk("rst_run", {15'b0, mcrRun}, 16'h0001);
        chk("rst_kbdready", {15'b0, kbdReady}, 16'h0001);
        MAROut = 16'hFE04;
        #1;
        chk("rst_dsr", MDRIn, 16'h8000);
        MAROut = 16'hFE02;
        #1;
        chk("rst_kbdr", MDRIn, 16'h0000);
        reset = 1'b1;
        tick();

        // Random traffic checked against the model.
        for (int n = 0; n < 600; n++) begin
            logic [15:0] mar;
            case ($urandom_range(0, 5))
                0: mar = 16'hFE00;
                1: mar = 16'hFE02;
                2: mar = 16'hFE04;
                3: mar = 16'hFE06;
                4: mar = 16'hFFFE;
                default: mar = 16'($urandom);
            endcase
            drive(mar, 16'($urandom), ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 5),
                  1'($urandom), 8'($urandom), 1'($urandom), 16'($urandom));
            #2;
            check_model();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
